// File: rtl/memory_op_controller.sv
// memory_op_controller: sequences store/recall/clear ops on the calculator memory datapath.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   storeKey          store key level
//   recallKey         recall key level
//   clearKey          memory-clear key level
//   busy              main FSM busy; new ops are not accepted
//   bcdOutputMemory   memory result from the datapath
//   memoryFlag        op code to datapath in [1:0] (01 store, 10 recall, 11 clear)
//   bcdInputMemory    stored memory {sign, 3 BCD digits} fed back to the datapath
//   memValid          memory holds a stored value
//   displayLoad       1-cycle pulse: datapath output valid
//   opDone            1-cycle pulse: op finished
//   recallError       1-cycle pulse: recall requested with empty memory
module memory_op_controller #(
    parameter int HOLD_CYCLES = 2,
    parameter int FLAG_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              storeKey,
    input  logic              recallKey,
    input  logic              clearKey,
    input  logic              busy,
    input  logic [12:0]       bcdOutputMemory,
    output logic [FLAG_W-1:0] memoryFlag,
    output logic [12:0]       bcdInputMemory,
    output logic              memValid,
    output logic              displayLoad,
    output logic              opDone,
    output logic              recallError
);
    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, APPLY, CAPTURE, WAITREL} state_t;

    state_t        state, state_n;
    logic [1:0]    op, op_n, sel_op;
    logic [CW-1:0] cnt;
    logic          store_q, recall_q, clear_q;
    logic          store_e, recall_e, clear_e;

    assign store_e  = storeKey & ~store_q;
    assign recall_e = recallKey & ~recall_q;
    assign clear_e  = clearKey & ~clear_q;
    // clear > store > recall when edges coincide
    assign sel_op = clear_e ? 2'b11 : store_e ? 2'b01 : recall_e ? 2'b10 : 2'b00;

    assign memoryFlag  = {{(FLAG_W-2){1'b0}}, (state == APPLY) ? op : 2'b00};
    assign displayLoad = (state == CAPTURE);
    assign opDone      = (state == CAPTURE);

    always_comb begin
        state_n     = state;
        op_n        = op;
        recallError = 1'b0;
        case (state)
            IDLE: if (!busy && sel_op != 2'b00) begin
                op_n = sel_op;
                if (sel_op == 2'b10 && !memValid) begin
                    recallError = 1'b1;
                    state_n     = WAITREL;
                end else begin
                    state_n = SETUP;
                end
            end
            SETUP:   state_n = APPLY;
            APPLY:   state_n = (cnt == LAST) ? CAPTURE : APPLY;
            CAPTURE: state_n = WAITREL;
            WAITREL: state_n = (storeKey | recallKey | clearKey) ? WAITREL : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op             <= 2'b00;
            cnt            <= '0;
            store_q        <= 1'b0;
            recall_q       <= 1'b0;
            clear_q        <= 1'b0;
            bcdInputMemory <= 13'b0;
            memValid       <= 1'b0;
        end else begin
            state    <= state_n;
            op       <= op_n;
            store_q  <= storeKey;
            recall_q <= recallKey;
            clear_q  <= clearKey;
            cnt      <= (state == APPLY && cnt != LAST) ? cnt + 1'b1 : '0;
            if (state == CAPTURE) begin
                bcdInputMemory <= (op == 2'b11) ? 13'b0 : bcdOutputMemory;
                memValid       <= (op == 2'b01) ? 1'b1 : (op == 2'b11) ? 1'b0 : memValid;
            end
        end
    end
endmodule

// File: tb/tb_memory_op_controller.sv
// tb_memory_op_controller: directed self-checking bench for memory_op_controller.
module tb_memory_op_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        storeKey, recallKey, clearKey, busy;
    logic [12:0] bcdOutputMemory;
    logic [4:0]  memoryFlag;
    logic [12:0] bcdInputMemory;
    logic        memValid, displayLoad, opDone, recallError;
    int          checks = 0;
    int          errors = 0;
    int          pulses;

    memory_op_controller dut (
        .clk(clk), .rst(rst),
        .storeKey(storeKey), .recallKey(recallKey), .clearKey(clearKey),
        .busy(busy), .bcdOutputMemory(bcdOutputMemory),
        .memoryFlag(memoryFlag), .bcdInputMemory(bcdInputMemory),
        .memValid(memValid), .displayLoad(displayLoad),
        .opDone(opDone), .recallError(recallError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key already raised at this negedge (cycle 0); walks cycles 0..5.
    task automatic op_seq(input string tag, input logic [1:0] code);
        #1;
        chk({tag, "_c0_flag"}, memoryFlag, 0);
        chk({tag, "_c0_dl"}, displayLoad, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d_flag", tag, c), memoryFlag, (c == 2 || c == 3) ? {3'b0, code} : 5'b0);
            chk($sformatf("%s_c%0d_dl", tag, c), displayLoad, c == 4);
            chk($sformatf("%s_c%0d_done", tag, c), opDone, c == 4);
        end
    endtask

    task automatic release_keys;
        storeKey = 0; recallKey = 0; clearKey = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; storeKey = 0; recallKey = 0; clearKey = 0; busy = 0;
        bcdOutputMemory = 13'h0;
        @(negedge clk);
        chk("rst_flag", memoryFlag, 0);
        chk("rst_mem", bcdInputMemory, 0);
        chk("rst_valid", memValid, 0);
        chk("rst_dl", displayLoad, 0);
        chk("rst_done", opDone, 0);
        chk("rst_rerr", recallError, 0);
        rst = 0;
        @(negedge clk);

        // recall with empty memory
        recallKey = 1;
        #1;
        chk("rempty_rerr", recallError, 1);
        chk("rempty_flag", memoryFlag, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulses += displayLoad;
            chk($sformatf("rempty_flag_%0d", i), memoryFlag, 0);
            chk($sformatf("rempty_rerr_%0d", i), recallError, 0);
        end
        chk("rempty_dl_count", pulses, 0);
        release_keys();

        // store positive 123
        bcdOutputMemory = 13'h0123;
        storeKey = 1;
        op_seq("store", 2'b01);
        chk("store_mem", bcdInputMemory, 13'h0123);
        chk("store_valid", memValid, 1);
        release_keys();

        // store negative 045
        bcdOutputMemory = 13'h1045;
        storeKey = 1;
        op_seq("storeneg", 2'b01);
        chk("storeneg_mem", bcdInputMemory, 13'h1045);
        release_keys();

        // recall: datapath echoes memory back
        recallKey = 1;
        #1;
        chk("recall_rerr", recallError, 0);
        op_seq("recall", 2'b10);
        chk("recall_mem", bcdInputMemory, 13'h1045);
        chk("recall_valid", memValid, 1);
        release_keys();

        // clear + store same cycle: clear wins
        bcdOutputMemory = 13'h0;
        clearKey = 1; storeKey = 1;
        op_seq("clear", 2'b11);
        chk("clear_mem", bcdInputMemory, 0);
        chk("clear_valid", memValid, 0);
        release_keys();

        // edge while busy is dropped
        busy = 1;
        bcdOutputMemory = 13'h0555;
        storeKey = 1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulses += displayLoad;
            chk($sformatf("busy_flag_%0d", i), memoryFlag, 0);
        end
        chk("busy_dl_count", pulses, 0);
        storeKey = 0;
        @(negedge clk);
        busy = 0;
        @(negedge clk);
        chk("busy_valid", memValid, 0);
        chk("busy_mem", bcdInputMemory, 0);

        // held key: exactly one op
        bcdOutputMemory = 13'h0777;
        storeKey = 1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulses += displayLoad;
        end
        chk("held_dl_count", pulses, 1);
        chk("held_mem", bcdInputMemory, 13'h0777);
        chk("held_valid", memValid, 1);
        release_keys();
        bcdOutputMemory = 13'h0888;
        storeKey = 1;
        op_seq("repress", 2'b01);
        chk("repress_mem", bcdInputMemory, 13'h0888);
        release_keys();

        // reset mid-APPLY
        bcdOutputMemory = 13'h0999;
        storeKey = 1;
        @(negedge clk);
        @(negedge clk);
        chk("midop_flag", memoryFlag, 1);
        rst = 1;
        #1;
        chk("midrst_flag", memoryFlag, 0);
        chk("midrst_mem", bcdInputMemory, 0);
        chk("midrst_valid", memValid, 0);
        chk("midrst_dl", displayLoad, 0);
        storeKey = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("postrst_flag", memoryFlag, 0);
        chk("postrst_dl", displayLoad, 0);
        bcdOutputMemory = 13'h0321;
        storeKey = 1;
        op_seq("postrst", 2'b01);
        chk("postrst_mem", bcdInputMemory, 13'h0321);
        release_keys();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
